// File: rtl/spi_slave_core_p.sv
// rtl/spi_slave_core_p.sv - parameterised SPI slave core with one-word TX holding register
//
// Purpose: SPI slave (configurable width, CPOL/CPHA, bit order) running entirely
// in the i_clk domain. SPI pins are oversampled through synchronisers.
//
// Ports:
//   i_clk, w_reset      system clock, synchronous active-high reset
//   i_spi_cs_n/sck/si   asynchronous SPI pins (chip select, clock, MOSI)
//   o_spi_so, _oe       MISO data and output enable (enable while selected)
//   i_tx_data/valid     next TX word offer; o_tx_ready = holding register empty
//   o_rx_data/valid     last complete RX word and its 1-cycle strobe
//   o_tx_underrun       1-cycle pulse: a word started with the holding register empty
//   o_frame_end         1-cycle pulse on chip-select deassertion
//   o_busy              chip select asserted (synchronised)

module spi_slave_core_p #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              w_reset,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_sck,
  input  logic              i_spi_si,
  output logic              o_spi_so,
  output logic              o_spi_so_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_tx_underrun,
  output logic              o_frame_end,
  output logic              o_busy
);

  localparam logic P_CPOL = (CPOL != 0);
  localparam logic P_CPHA = (CPHA != 0);
  localparam logic P_MSB  = (MSB_FIRST != 0);
  localparam int   CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_si_sync;
  logic r_cs_d, r_sck_d;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx_shift, r_tx_shift, r_hold_data, r_rx_data;
  logic r_hold_full, r_rx_valid, r_underrun, r_frame_end;

  logic w_cs, w_sck, w_si;
  logic w_cs_fall, w_cs_rise, w_sck_edge, w_lead, w_trail;
  logic w_sample_edge, w_shift_edge;
  logic w_do_start, w_do_stop, w_do_sample, w_do_shift, w_load, w_tx_hs;
  logic [DATA_W-1:0] w_rx_next;

  // Synchronisers; reset to the idle pin levels so release of reset with the
  // bus idle produces no spurious edges.
  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      r_cs_sync  <= '1;
      r_sck_sync <= {SYNC_STAGES{P_CPOL}};
      r_si_sync  <= '0;
      r_cs_d     <= 1'b1;
      r_sck_d    <= P_CPOL;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], i_spi_si};
      r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_cs  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_si  = r_si_sync[SYNC_STAGES-1];

  assign w_cs_fall  = r_cs_d & ~w_cs;
  assign w_cs_rise  = ~r_cs_d & w_cs;
  assign w_sck_edge = w_sck ^ r_sck_d;
  assign w_lead     = w_sck_edge & (w_sck != P_CPOL);
  assign w_trail    = w_sck_edge & (w_sck == P_CPOL);

  assign w_sample_edge = P_CPHA ? w_trail : w_lead;
  assign w_shift_edge  = P_CPHA ? w_lead  : w_trail;

  always_ff @(posedge i_clk) begin
    if (w_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // SCK edges only act while ACTIVE and not in the cycle CS rises.
  always_comb begin
    w_state_nxt = r_state;
    w_do_start  = 1'b0;
    w_do_stop   = 1'b0;
    w_do_sample = 1'b0;
    w_do_shift  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_do_start  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_do_stop   = 1'b1;
        end else begin
          w_do_sample = w_sample_edge;
          w_do_shift  = w_shift_edge;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // CPHA=0 presents the first bit before any clock, so the first word loads at
  // CS fall; later words (and all CPHA=1 words) load on a shift edge at bit 0.
  assign w_load  = (w_do_start & ~P_CPHA) | (w_do_shift & (r_bit_cnt == '0));
  assign w_tx_hs = i_tx_valid & ~r_hold_full;

  assign w_rx_next = P_MSB ? {r_rx_shift[DATA_W-2:0], w_si}
                           : {w_si, r_rx_shift[DATA_W-1:1]};

  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_underrun  <= w_load & ~r_hold_full;
      r_frame_end <= w_do_stop;

      if (w_do_start || w_do_stop) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_do_sample) begin
        r_rx_shift <= w_rx_next;
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end

      if (w_load)
        r_tx_shift <= r_hold_full ? r_hold_data : '0;
      else if (w_do_shift)
        r_tx_shift <= P_MSB ? {r_tx_shift[DATA_W-2:0], 1'b0}
                            : {1'b0, r_tx_shift[DATA_W-1:1]};
      else if (w_do_stop)
        r_tx_shift <= '0;

      // A handshake can only occur while empty; a coincident load has then
      // already underrun, so the new word waits for the next word slot.
      if (w_tx_hs) begin
        r_hold_data <= i_tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign o_busy        = (r_state == ST_ACTIVE);
  assign o_spi_so_oe   = o_busy;
  assign o_spi_so      = o_busy & (P_MSB ? r_tx_shift[DATA_W-1] : r_tx_shift[0]);
  assign o_tx_ready    = ~r_hold_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_underrun;
  assign o_frame_end   = r_frame_end;

endmodule

// File: tb/tb_spi_slave_core_p.sv
// tb/tb_spi_slave_core_p.sv - self-checking bench for spi_slave_core_p (mode 0/8b MSB and mode 3/16b LSB)

module tb_spi_slave_core_p;

  localparam int H   = 6;
  localparam int TMO = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  cs_n, sck, si, tx_valid;
  logic [7:0]  txd0;
  logic [15:0] txd1;
  wire  [1:0]  so, oe, tx_ready, rx_valid, underrun, frame_end, busy;
  wire  [7:0]  rxd0;
  wire  [15:0] rxd1;

  spi_slave_core_p #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
    .i_clk(clk), .w_reset(rst), .i_spi_cs_n(cs_n[0]), .i_spi_sck(sck[0]), .i_spi_si(si[0]),
    .o_spi_so(so[0]), .o_spi_so_oe(oe[0]), .i_tx_data(txd0), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(tx_ready[0]), .o_rx_data(rxd0), .o_rx_valid(rx_valid[0]),
    .o_tx_underrun(underrun[0]), .o_frame_end(frame_end[0]), .o_busy(busy[0]));

  spi_slave_core_p #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut1 (
    .i_clk(clk), .w_reset(rst), .i_spi_cs_n(cs_n[1]), .i_spi_sck(sck[1]), .i_spi_si(si[1]),
    .o_spi_so(so[1]), .o_spi_so_oe(oe[1]), .i_tx_data(txd1), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(tx_ready[1]), .o_rx_data(rxd1), .o_rx_valid(rx_valid[1]),
    .o_tx_underrun(underrun[1]), .o_frame_end(frame_end[1]), .o_busy(busy[1]));

  int n_pass = 0;
  int n_tot  = 0;
  int n_ur   = 0;
  int n_fe   = 0;
  logic [31:0] q_rx[$];
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] mosi_w[4];
  logic [31:0] miso_w[4];
  logic [31:0] exp_miso[4];

  typedef struct {
    int          d;
    int          nbits;
    bit          push;
    logic [31:0] tx;
    logic [31:0] mosi;
    logic [31:0] exp_miso;
    int          exp_nrx;
    int          exp_ur;
  } vec_t;

  function automatic int wid(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic logic [31:0] rxd(input int d);
    return (d == 0) ? {24'b0, rxd0} : {16'b0, rxd1};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rx_valid[d])  q_rx.push_back(rxd(d));
      if (underrun[d])  n_ur++;
      if (frame_end[d]) n_fe++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic check_reset(input int d);
    check($sformatf("reset tx_ready[%0d]", d), {31'b0, tx_ready[d]}, 32'd1);
    check($sformatf("reset busy[%0d]", d), {31'b0, busy[d]}, 32'd0);
    check($sformatf("reset oe[%0d]", d), {31'b0, oe[d]}, 32'd0);
    check($sformatf("reset so[%0d]", d), {31'b0, so[d]}, 32'd0);
    check($sformatf("reset rx_valid[%0d]", d), {31'b0, rx_valid[d]}, 32'd0);
    check($sformatf("reset underrun[%0d]", d), {31'b0, underrun[d]}, 32'd0);
    check($sformatf("reset frame_end[%0d]", d), {31'b0, frame_end[d]}, 32'd0);
    check($sformatf("reset rx_data[%0d]", d), rxd(d), 32'd0);
  endtask

  // Offer one word; the handshake completes on the first edge with ready high.
  task automatic push_tx(input int d, input logic [31:0] w);
    bit done = 1'b0;
    txd0 = w[7:0];
    txd1 = w[15:0];
    tx_valid[d] = 1'b1;
    for (int t = 0; t < TMO && !done; t++) begin
      if (tx_ready[d]) done = 1'b1;
      tick();
    end
    tx_valid[d] = 1'b0;
    check($sformatf("push_tx handshake[%0d]", d), {31'b0, done}, 32'd1);
    if (done) begin
      if (d == 0) mq0.push_back(w);
      else        mq1.push_back(w);
    end
  endtask

  // SPI master: mode 0 MSB-first 8-bit for d=0, mode 3 LSB-first 16-bit for d=1.
  task automatic run_frame(input int d, input int nbits);
    int   w    = wid(d);
    logic pol  = (d == 1);
    bit   cpha = (d == 1);
    cs_n[d] = 1'b0;
    repeat (H) tick();
    for (int b = 0; b < nbits; b++) begin
      int   wi  = b / w;
      int   bi  = b % w;
      int   pos = (d == 0) ? (w - 1 - bi) : bi;
      logic [31:0] mw = mosi_w[wi];
      if (!cpha) begin
        si[d] = mw[pos];
        repeat (H) tick();
        miso_w[wi][pos] = so[d];
        sck[d] = ~pol;
        repeat (H) tick();
        sck[d] = pol;
      end else begin
        sck[d] = ~pol;
        si[d]  = mw[pos];
        repeat (H) tick();
        miso_w[wi][pos] = so[d];
        sck[d] = pol;
        repeat (H) tick();
      end
    end
    repeat (H) tick();
    cs_n[d] = 1'b1;
    repeat (8) tick();
  endtask

  // Reference: every word slot takes the oldest offered word or underruns.
  // CPHA=0 fills a slot at CS fall and after each complete word; CPHA=1 fills
  // a slot at the start of every word clocked.
  task automatic model_frame(input int d, input int nbits, output int exp_nrx, output int exp_ur);
    int w     = wid(d);
    int words = (nbits + w - 1) / w;
    int full  = nbits / w;
    int slots = (d == 1) ? words : full + 1;
    logic [31:0] lw;
    exp_ur  = 0;
    exp_nrx = full;
    for (int i = 0; i < 4; i++) exp_miso[i] = '0;
    for (int i = 0; i < slots; i++) begin
      if (d == 0 && mq0.size() > 0)      lw = mq0.pop_front();
      else if (d == 1 && mq1.size() > 0) lw = mq1.pop_front();
      else begin
        lw = '0;
        exp_ur++;
      end
      if (i < words) exp_miso[i] = lw;
    end
  endtask

  task automatic clear_obs();
    q_rx.delete();
    n_ur = 0;
    n_fe = 0;
    for (int i = 0; i < 4; i++) miso_w[i] = '0;
  endtask

  task automatic run_and_check(input string tag, input int d, input int nbits,
                               input int exp_nrx, input int exp_ur);
    int words = (nbits + wid(d) - 1) / wid(d);
    bit empty = (d == 0) ? (mq0.size() == 0) : (mq1.size() == 0);
    clear_obs();
    run_frame(d, nbits);
    for (int i = 0; i < words; i++)
      check($sformatf("%s miso[%0d]", tag, i), miso_w[i], exp_miso[i]);
    check($sformatf("%s rx_count", tag), 32'(q_rx.size()), 32'(exp_nrx));
    for (int i = 0; i < exp_nrx && i < q_rx.size(); i++)
      check($sformatf("%s rx[%0d]", tag, i), q_rx[i], mosi_w[i]);
    check($sformatf("%s underruns", tag), 32'(n_ur), 32'(exp_ur));
    check($sformatf("%s frame_end", tag), 32'(n_fe), 32'd1);
    check($sformatf("%s tx_ready", tag), {31'b0, tx_ready[d]}, {31'b0, empty});
    check($sformatf("%s busy", tag), {31'b0, busy[d]}, 32'd0);
  endtask

  initial begin
    vec_t vt[5];
    int   m_nrx, m_ur;

    vt[0] = '{0,  8, 1'b1, 32'hA5,   32'h3C,   32'hA5,   1, 1};
    vt[1] = '{1, 16, 1'b1, 32'h1234, 32'hBEEF, 32'h1234, 1, 0};
    vt[2] = '{0,  5, 1'b1, 32'hC3,   32'h9F,   32'hC0,   0, 0};
    vt[3] = '{0,  8, 1'b0, 32'h00,   32'h81,   32'h00,   1, 2};
    vt[4] = '{1, 16, 1'b1, 32'h8001, 32'hFFFF, 32'h8001, 1, 0};

    rst = 1'b1;
    cs_n = 2'b11;
    sck = 2'b10;
    si = 2'b00;
    tx_valid = 2'b00;
    txd0 = '0;
    txd1 = '0;
    repeat (4) tick();
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      if (vt[i].push) push_tx(vt[i].d, vt[i].tx);
      mosi_w[0] = vt[i].mosi;
      model_frame(vt[i].d, vt[i].nbits, m_nrx, m_ur);
      exp_miso[0] = vt[i].exp_miso;
      run_and_check($sformatf("vec%0d", i), vt[i].d, vt[i].nbits, vt[i].exp_nrx, vt[i].exp_ur);
    end

    for (int it = 0; it < 24; it++) begin
      int d  = int'($urandom_range(1, 0));
      int nw = int'($urandom_range(3, 1));
      logic [31:0] mask = (d == 0) ? 32'hFF : 32'hFFFF;
      bit empty = (d == 0) ? (mq0.size() == 0) : (mq1.size() == 0);
      if (empty && $urandom_range(1, 0) == 1) push_tx(d, $urandom & mask);
      for (int k = 0; k < 4; k++) mosi_w[k] = $urandom & mask;
      model_frame(d, nw * wid(d), m_nrx, m_ur);
      run_and_check($sformatf("rnd%0d", it), d, nw * wid(d), m_nrx, m_ur);
    end

    // Reset in the middle of a word, then a clean frame afterwards.
    push_tx(0, 32'h77);
    mosi_w[0] = 32'hFF;
    fork
      run_frame(0, 8);
      begin
        repeat (40) tick();
        rst = 1'b1;
        tick();
        check_reset(0);
      end
    join
    tick();
    rst = 1'b0;
    mq0.delete();
    mq1.delete();
    repeat (2) tick();
    push_tx(0, 32'h3C);
    mosi_w[0] = 32'h5A;
    model_frame(0, 8, m_nrx, m_ur);
    run_and_check("reset_recover", 0, 8, m_nrx, m_ur);
    check("reset_recover rx_data", rxd(0), 32'h5A);

    // Handshake in the very cycle of the CS-fall load with the holding register empty.
    clear_obs();
    mosi_w[0] = 32'h11;
    mosi_w[1] = 32'hE7;
    fork
      run_frame(0, 16);
      begin
        repeat (2) tick();
        txd0 = 8'h96;
        tx_valid[0] = 1'b1;
        tick();
        check("hs_same_cycle underrun pulse", {31'b0, underrun[0]}, 32'd1);
        check("hs_same_cycle ready low", {31'b0, tx_ready[0]}, 32'd0);
        tx_valid[0] = 1'b0;
      end
    join
    check("hs_same_cycle miso[0]", miso_w[0], 32'h00);
    check("hs_same_cycle miso[1]", miso_w[1], 32'h96);
    check("hs_same_cycle underruns", 32'(n_ur), 32'd2);
    check("hs_same_cycle rx_count", 32'(q_rx.size()), 32'd2);
    if (q_rx.size() == 2) begin
      check("hs_same_cycle rx[0]", q_rx[0], 32'h11);
      check("hs_same_cycle rx[1]", q_rx[1], 32'hE7);
    end

    // Back-to-back words in one mode-3 frame; third slot has nothing to send.
    mq1.delete();
    push_tx(1, 32'h0011);
    clear_obs();
    mosi_w[0] = 32'hA1B2;
    mosi_w[1] = 32'hC3D4;
    mosi_w[2] = 32'hE5F6;
    fork
      run_frame(1, 48);
      push_tx(1, 32'h0022);
    join
    check("b2b miso[0]", miso_w[0], 32'h0011);
    check("b2b miso[1]", miso_w[1], 32'h0022);
    check("b2b miso[2]", miso_w[2], 32'h0000);
    check("b2b underruns", 32'(n_ur), 32'd1);
    check("b2b frame_end", 32'(n_fe), 32'd1);
    check("b2b rx_count", 32'(q_rx.size()), 32'd3);
    if (q_rx.size() == 3) begin
      check("b2b rx[0]", q_rx[0], 32'hA1B2);
      check("b2b rx[1]", q_rx[1], 32'hC3D4);
      check("b2b rx[2]", q_rx[2], 32'hE5F6);
    end
    mq1.delete();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
